// File: rtl/zxb_pkg.sv
// Shared definitions for the ZX-bus target: FSM encoding, register indices,
// front-end request select codes and the SRAM address composition helper.
package zxb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PORT    = 3'd1,
    MEM_ACT = 3'd2,
    MEM_END = 3'd3,
    STB     = 3'd4,
    REL     = 3'd5
  } zxb_state_e;

  localparam logic [2:0] REG_PAGE = 3'd0;
  localparam logic [2:0] REG_ID   = 3'd7;

  // Request select codes used by the front-end when routing a bus cycle.
  localparam logic [1:0] FCI_NONE = 2'd0;
  localparam logic [1:0] FCI_PORT = 2'd1;
  localparam logic [1:0] FCI_MEM  = 2'd2;

  // 16 KB window offset placed inside the selected 512 KB SRAM page.
  function automatic logic [18:0] sram_addr_f(input logic [4:0]  page,
                                              input logic [13:0] offset);
    return {page, offset};
  endfunction

endpackage

// File: rtl/zxb_regfile.sv
// 8x8 register file: reg 0 is the 5-bit PAGE register, reg 7 is a read-only ID,
// regs 1-6 are plain scratch. Synchronous write, combinational read.
module zxb_regfile
  import zxb_pkg::*;
#(
  parameter logic [7:0] DEV_ID = 8'h5A
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       we_i,
  input  logic [2:0] idx_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic [4:0] page_o
);

  logic [4:0] page_q;
  logic [7:0] scratch_q [1:6];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      page_q <= 5'd0;
      for (int i = 1; i <= 6; i++) begin
        scratch_q[i] <= 8'h00;
      end
    end else if (we_i) begin
      if (idx_i == REG_PAGE) begin
        page_q <= wdata_i[4:0];
      end else if (idx_i != REG_ID) begin
        scratch_q[idx_i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = 8'h00;
    case (idx_i)
      REG_PAGE: rdata_o = {3'b000, page_q};
      REG_ID:   rdata_o = DEV_ID;
      default:  rdata_o = scratch_q[idx_i];
    endcase
  end

  assign page_o = page_q;

endmodule

// File: rtl/zxb_target.sv
// ZX-bus internal responder: decodes the Z80 address, serves port requests from
// the register file and memory requests from async SRAM through a paged window.
module zxb_target
  import zxb_pkg::*;
#(
  parameter logic [7:0] PORT_LO  = 8'hAF,
  parameter logic [1:0] WIN_BANK = 2'b11,
  parameter int         SRAM_WS  = 2,
  parameter logic [7:0] DEV_ID   = 8'h5A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] zaddr,
  input  logic [7:0]  zdata_in,
  input  logic        zxb_rnw,
  input  logic        zxb_mni,
  input  logic        mem_req,
  input  logic        port_req,
  output logic        zxb_en,
  output logic        mem_stb,
  output logic        port_stb,
  output logic [7:0]  zdata_out,
  output logic [18:0] sram_addr,
  output logic [7:0]  sram_dq_o,
  input  logic [7:0]  sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output zxb_state_e  dbg_state
);

  localparam logic [2:0] WS_LAST = SRAM_WS[2:0];

  // Handshake: the front-end raises mem_req or port_req as a level and keeps it
  // up until it has seen the matching one-cycle *_stb pulse; the target then
  // parks in REL until both requests are low, so one level yields one pulse.

  zxb_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        rnw_q, rnw_d;
  logic        abort_q, abort_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [18:0] addr_q, addr_d;
  logic [7:0]  zdata_q, zdata_d;
  logic        port_stb_q, port_stb_d;
  logic        mem_stb_q, mem_stb_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        dq_oe_q, dq_oe_d;

  logic        rf_we;
  logic [7:0]  rf_rdata;
  logic [4:0]  page;

  zxb_regfile #(.DEV_ID(DEV_ID)) u_regfile (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (rf_we),
    .idx_i   (zaddr[10:8]),
    .wdata_i (zdata_in),
    .rdata_o (rf_rdata),
    .page_o  (page)
  );

  assign zxb_en = zxb_mni ? (zaddr[15:14] == WIN_BANK) : (zaddr[7:0] == PORT_LO);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rnw_d      = rnw_q;
    abort_d    = abort_q;
    wdata_d    = wdata_q;
    addr_d     = addr_q;
    zdata_d    = zdata_q;
    port_stb_d = 1'b0;
    mem_stb_d  = 1'b0;
    rf_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          rnw_d   = zxb_rnw;
          wdata_d = zdata_in;
          addr_d  = sram_addr_f(page, zaddr[13:0]);
          cnt_d   = 3'd0;
          abort_d = 1'b0;
          state_d = MEM_ACT;
        end else if (port_req) begin
          state_d = PORT;
        end
      end
      PORT: begin
        rf_we      = !zxb_rnw;
        port_stb_d = 1'b1;
        if (zxb_rnw) zdata_d = rf_rdata;
        state_d = REL;
      end
      MEM_ACT: begin
        // A dropped request still runs the strobe to full length; only the
        // completion pulse and the read capture are suppressed.
        if (!mem_req) abort_d = 1'b1;
        if (cnt_q == WS_LAST) begin
          if (rnw_q && mem_req && !abort_q) zdata_d = sram_dq_i;
          state_d = MEM_END;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      MEM_END: state_d = abort_q ? REL : STB;
      STB: begin
        mem_stb_d = 1'b1;
        state_d   = REL;
      end
      REL: if (!mem_req && !port_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // SRAM controls are registered from the next state so the pins never glitch.
  always_comb begin
    ce_n_d  = (state_d != MEM_ACT);
    oe_n_d  = !((state_d == MEM_ACT) && rnw_d);
    we_n_d  = !((state_d == MEM_ACT) && !rnw_d);
    dq_oe_d = ((state_d == MEM_ACT) || (state_d == MEM_END)) && !rnw_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      rnw_q      <= 1'b1;
      abort_q    <= 1'b0;
      wdata_q    <= 8'h00;
      addr_q     <= 19'd0;
      zdata_q    <= 8'h00;
      port_stb_q <= 1'b0;
      mem_stb_q  <= 1'b0;
      ce_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      dq_oe_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rnw_q      <= rnw_d;
      abort_q    <= abort_d;
      wdata_q    <= wdata_d;
      addr_q     <= addr_d;
      zdata_q    <= zdata_d;
      port_stb_q <= port_stb_d;
      mem_stb_q  <= mem_stb_d;
      ce_n_q     <= ce_n_d;
      oe_n_q     <= oe_n_d;
      we_n_q     <= we_n_d;
      dq_oe_q    <= dq_oe_d;
    end
  end

  assign mem_stb    = mem_stb_q;
  assign port_stb   = port_stb_q;
  assign zdata_out  = zdata_q;
  assign sram_addr  = addr_q;
  assign sram_dq_o  = wdata_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_zxb_target.sv
// Directed bench for zxb_target: register file, paged SRAM window, decode,
// request-drop and asynchronous reset behaviour.
module tb_zxb_target;
  import zxb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] zaddr;
  logic [7:0]  zdata_in;
  logic        zxb_rnw;
  logic        zxb_mni;
  logic        mem_req;
  logic        port_req;
  logic        zxb_en;
  logic        mem_stb;
  logic        port_stb;
  logic [7:0]  zdata_out;
  logic [18:0] sram_addr;
  logic [7:0]  sram_dq_o;
  logic [7:0]  sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  zxb_state_e  dbg_state;

  int n_checks = 0;
  int n_fails  = 0;

  zxb_target #(
    .PORT_LO (8'hAF),
    .WIN_BANK(2'b11),
    .SRAM_WS (2),
    .DEV_ID  (8'h5A)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .zaddr     (zaddr),
    .zdata_in  (zdata_in),
    .zxb_rnw   (zxb_rnw),
    .zxb_mni   (zxb_mni),
    .mem_req   (mem_req),
    .port_req  (port_req),
    .zxb_en    (zxb_en),
    .mem_stb   (mem_stb),
    .port_stb  (port_stb),
    .zdata_out (zdata_out),
    .sram_addr (sram_addr),
    .sram_dq_o (sram_dq_o),
    .sram_dq_i (sram_dq_i),
    .sram_dq_oe(sram_dq_oe),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Port access: strobe must appear exactly two edges after the request.
  task automatic port_access(input logic [15:0] a, input logic [7:0] d, input logic rnw);
    zaddr = a; zdata_in = d; zxb_rnw = rnw; zxb_mni = 1'b0; port_req = 1'b1;
    @(negedge clk);
    check("port_stb_early", 32'(port_stb), 32'd0);
    @(negedge clk);
    check("port_stb", 32'(port_stb), 32'd1);
    check("port_no_mem_stb", 32'(mem_stb), 32'd0);
    port_req = 1'b0;
    @(negedge clk);
    check("port_stb_pulse", 32'(port_stb), 32'd0);
    check("port_back_idle", 32'(dbg_state), 32'(IDLE));
  endtask

  // SRAM_WS = 2: strobe low on edges 1-3, MEM_END on edge 4, mem_stb after edge 6.
  // The request is held 10 cycles past the strobe to prove a single pulse.
  task automatic mem_access(input logic [15:0] a, input logic [7:0] d, input logic rnw,
                            input logic [18:0] exp_addr);
    zaddr = a; zdata_in = d; zxb_rnw = rnw; zxb_mni = 1'b1; mem_req = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      check($sformatf("mem_stb_c%0d", i), 32'(mem_stb), 32'(i == 6));
      if (i <= 3) begin
        check($sformatf("ce_n_c%0d", i), 32'(sram_ce_n), 32'd0);
        check($sformatf("oe_n_c%0d", i), 32'(sram_oe_n), 32'(!rnw));
        check($sformatf("we_n_c%0d", i), 32'(sram_we_n), 32'(rnw));
        check($sformatf("addr_c%0d", i), 32'(sram_addr), 32'(exp_addr));
      end else if (i <= 5) begin
        check($sformatf("ce_n_c%0d", i), 32'(sram_ce_n), 32'd1);
        check($sformatf("we_n_c%0d", i), 32'(sram_we_n), 32'd1);
        check($sformatf("oe_n_c%0d", i), 32'(sram_oe_n), 32'd1);
      end
      if (!rnw && i <= 4) begin
        check($sformatf("dq_oe_c%0d", i), 32'(sram_dq_oe), 32'd1);
        check($sformatf("dq_o_c%0d", i), 32'(sram_dq_o), 32'(d));
        check($sformatf("hold_addr_c%0d", i), 32'(sram_addr), 32'(exp_addr));
      end
      if (i == 5) check("dq_oe_released", 32'(sram_dq_oe), 32'd0);
    end
    mem_req = 1'b0;
    @(negedge clk);
    check("mem_back_idle", 32'(dbg_state), 32'(IDLE));
    check("mem_stb_after_drop", 32'(mem_stb), 32'd0);
  endtask

  initial begin
    reset = 1'b1; zaddr = 16'h0000; zdata_in = 8'h00; zxb_rnw = 1'b1; zxb_mni = 1'b0;
    mem_req = 1'b0; port_req = 1'b0; sram_dq_i = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_mem_stb", 32'(mem_stb), 32'd0);
    check("rst_port_stb", 32'(port_stb), 32'd0);
    check("rst_zdata", 32'(zdata_out), 32'h00);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("rst_ce_n", 32'(sram_ce_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);

    // Scratch register write/read.
    port_access(16'h03AF, 8'h77, 1'b0);
    port_access(16'h03AF, 8'h00, 1'b1);
    check("scratch_rd", 32'(zdata_out), 32'h77);

    // ID is read-only, PAGE keeps five bits.
    port_access(16'h07AF, 8'hFF, 1'b0);
    port_access(16'h07AF, 8'h00, 1'b1);
    check("id_rd", 32'(zdata_out), 32'h5A);
    port_access(16'h00AF, 8'hFF, 1'b0);
    port_access(16'h00AF, 8'h00, 1'b1);
    check("page_rd", 32'(zdata_out), 32'h1F);

    // Memory read through page 3.
    port_access(16'h00AF, 8'h03, 1'b0);
    check("zdata_kept_on_write", 32'(zdata_out), 32'h1F);
    sram_dq_i = 8'hA5;
    mem_access(16'hC123, 8'h00, 1'b1, 19'h0C123);
    check("mem_rd_data", 32'(zdata_out), 32'hA5);

    // Memory write through page 0.
    port_access(16'h00AF, 8'h00, 1'b0);
    sram_dq_i = 8'h00;
    mem_access(16'hFFFF, 8'h3C, 1'b0, 19'h03FFF);
    check("zdata_kept_after_mem_wr", 32'(zdata_out), 32'hA5);

    // Request dropped mid-access: cycle completes, no strobe, no capture.
    sram_dq_i = 8'h11;
    zaddr = 16'hC000; zxb_rnw = 1'b1; zxb_mni = 1'b1; mem_req = 1'b1;
    @(negedge clk);
    mem_req = 1'b0;
    for (int i = 2; i <= 7; i++) begin
      @(negedge clk);
      check($sformatf("abort_stb_c%0d", i), 32'(mem_stb), 32'd0);
      if (i <= 3) check($sformatf("abort_ce_n_c%0d", i), 32'(sram_ce_n), 32'd0);
    end
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_zdata", 32'(zdata_out), 32'hA5);

    // Address decode.
    zxb_mni = 1'b1; zaddr = 16'h8000; #1;
    check("dec_mem_miss", 32'(zxb_en), 32'd0);
    zaddr = 16'hC123; #1;
    check("dec_mem_hit", 32'(zxb_en), 32'd1);
    zxb_mni = 1'b0; zaddr = 16'h00AE; #1;
    check("dec_port_miss", 32'(zxb_en), 32'd0);
    zaddr = 16'h03AF; #1;
    check("dec_port_hit", 32'(zxb_en), 32'd1);
    zaddr = 16'hC0AE; #1;
    check("dec_io_ignores_bank", 32'(zxb_en), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_no_mem_stb", 32'(mem_stb), 32'd0);
    check("idle_no_port_stb", 32'(port_stb), 32'd0);

    // Asynchronous reset in the middle of an SRAM write.
    zaddr = 16'hD000; zdata_in = 8'h99; zxb_rnw = 1'b0; zxb_mni = 1'b1; mem_req = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_ce_n", 32'(sram_ce_n), 32'd0);
    check("pre_rst_dq_oe", 32'(sram_dq_oe), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_ce_n", 32'(sram_ce_n), 32'd1);
    check("arst_we_n", 32'(sram_we_n), 32'd1);
    check("arst_dq_oe", 32'(sram_dq_oe), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    check("arst_zdata", 32'(zdata_out), 32'h00);
    mem_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_state", 32'(dbg_state), 32'(IDLE));
    port_access(16'h07AF, 8'h00, 1'b1);
    check("post_rst_id", 32'(zdata_out), 32'h5A);
    port_access(16'h03AF, 8'h00, 1'b1);
    check("post_rst_scratch", 32'(zdata_out), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/zxb_target.md
Name: zxb_target

Overview:
- Internal responder for the ZX-bus front-end request/strobe handshake.
- Decodes the captured Z80 address and returns `zxb_en`.
- Services `port_req` from an 8-entry register file and `mem_req` from an external async SRAM through a 16 KB paged window.
- Returns read data and one-cycle `port_stb`/`mem_stb` completion pulses.

Parameters:
- PORT_LO, 8'hAF, low address byte that selects the register file.
- WIN_BANK, 2'b11, `zaddr[15:14]` value that selects the SRAM window (0xC000-0xFFFF).
- SRAM_WS, 2, extra SRAM strobe cycles, legal range 0..7.
- DEV_ID, 8'h5A, read-only value of register 7.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- zaddr  in  16  captured Z80 address
- zdata_in  in  8  captured Z80 write data
- zxb_rnw  in  1  1 = read, 0 = write
- zxb_mni  in  1  1 = memory cycle, 0 = I/O cycle
- mem_req  in  1  memory request level
- port_req  in  1  port request level
- zxb_en  out  1  address decoded as ours
- mem_stb  out  1  memory completion pulse
- port_stb  out  1  port completion pulse
- zdata_out  out  8  read data to the Z80 bus
- sram_addr  out  19  SRAM address
- sram_dq_o  out  8  SRAM write data
- sram_dq_i  in  8  SRAM read data
- sram_dq_oe  out  1  FPGA drives the SRAM DQ pins
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM controls, active low

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - `reset` is asynchronous and active-high; it overrides every state.
- Reset values:
  - All strobes 0, `zdata_out` 8'h00, `sram_addr` 0.
  - `sram_ce_n`/`sram_oe_n`/`sram_we_n` = 1, `sram_dq_oe` = 0.
  - Registers 0..6 = 8'h00; state = IDLE.
- Address decode (`zxb_en`), combinational:
  - When `zxb_mni` = 1: `zxb_en` = (`zaddr[15:14]` == WIN_BANK).
  - When `zxb_mni` = 0: `zxb_en` = (`zaddr[7:0]` == PORT_LO).
  - The front-end samples `zxb_en` only after both address bytes are valid.
- Register file:
  - Index is `zaddr[10:8]`.
  - Reg 0 = PAGE; only bits [4:0] are used and bits [7:5] read back 0.
  - Regs 1-6 are scratch.
  - Reg 7 reads DEV_ID; writes to it are ignored.
- SRAM address: `sram_addr` = {PAGE[4:0], `zaddr[13:0]`}.
- FSM states: IDLE, PORT, MEM_ACT, MEM_END, STB, REL.
- IDLE:
  - If `mem_req` is high, latch the access type and go to MEM_ACT.
  - Otherwise, if `port_req` is high, go to PORT.
  - `mem_req` wins when both are high; the protocol forbids that case.
- PORT:
  - Perform the register read or write.
  - Assert `port_stb` = 1 for this cycle only.
  - `zdata_out` is loaded at the same edge.
  - Go to REL.
- MEM_ACT:
  - Drive `sram_addr` with `sram_ce_n` = 0.
  - Read: `sram_oe_n` = 0.
  - Write: `sram_we_n` = 0, with `sram_dq_o` = `zdata_in` and `sram_dq_oe` = 1.
  - Hold for SRAM_WS+1 cycles, counted by a 3-bit counter.
  - On the last cycle of a read, capture `sram_dq_i` into `zdata_out`.
- MEM_END:
  - `sram_we_n`/`sram_oe_n` = 1 and `sram_ce_n` = 1.
  - Address and data are held one more cycle for write hold time.
  - Go to STB.
- STB: `mem_stb` = 1 for one cycle, then go to REL.
- REL: wait until both `mem_req` and `port_req` are 0, then go to IDLE. This blocks re-triggering while the front-end drops its request.
- Latency:
  - `port_req`↑ to `port_stb` is 2 cycles.
  - `mem_req`↑ to `mem_stb` is SRAM_WS+4 cycles.
- Data hold: `zdata_out` holds its value until the next read completes. Writes do not alter it.
- Request drop in MEM_ACT: if a request drops mid-access (front-end reset), complete the current SRAM cycle safely (MEM_END), skip the strobe, and go to REL.
- Reset mid-access: SRAM is deselected and DQ tristated immediately (asynchronous reset).
- Strobes are registered outputs; there are no combinational paths from any req to any stb.

Decomposition:
- Shared package `zxb_pkg`:
  - FSM state encoding.
  - Register index constants REG_PAGE = 3'd0, REG_ID = 3'd7.
  - FCI select constants shared with the front-end.
- Optional sub-module `zxb_regfile`: 8×8 file with the PAGE/ID special cases, synchronous write, combinational read.

Test Plan:
- Port write then read: `zaddr` = 16'h03AF, data 8'h77, `port_req`. Expect `port_stb` 2 cycles after req; the following read of 16'h03AF returns `zdata_out` = 8'h77.
- ID and PAGE readback:
  - Write 8'hFF to 16'h07AF, then read it back → 8'h5A.
  - Write 8'hFF to 16'h00AF (PAGE), then read it back → 8'h1F.
- Memory read, SRAM_WS = 2:
  - Setup: PAGE = 5'h03, `zaddr` = 16'hC123, SRAM model returns 8'hA5.
  - Expect `sram_addr` = 19'h0C123 with `sram_oe_n` low for 3 cycles.
  - Expect `mem_stb` at cycle 6 after req and `zdata_out` = 8'hA5.
- Memory write: `zaddr` = 16'hFFFF, 8'h3C, PAGE = 0. Expect `sram_we_n` low for 3 cycles with DQ driven to 8'h3C, and data held 1 cycle after `sram_we_n` rises.
- Decode: `zaddr` = 16'h8000 with `zxb_mni` = 1, and `zaddr` = 16'h00AE with `zxb_mni` = 0 → `zxb_en` = 0 in both cases; no strobe is ever issued.
- Reset and held request:
  - Assert reset during MEM_ACT → `sram_ce_n` = 1 and `sram_dq_oe` = 0 immediately; state is IDLE after release.
  - Hold `mem_req` high for 10 cycles after `mem_stb` → exactly one `mem_stb` pulse.
